serial_paralelo: RTL and testbench

- Receive-side deserializer: the stage directly downstream of paralelo_serial.
- Takes the 1-bit serial stream (MSB first, one bit per clk_32f cycle) and finds byte boundaries on the comma character 0xBC.
- After a run of aligned commas, rebuilds 8-bit words with a valid flag, one word per 8 clk_32f cycles. This is the equivalent of the clk_4f byte rate, generated internally.
- Idle commas are dropped: they give valid_out=0.

---
 rtl/serial_paralelo.sv | 154 +++++++++++++++
 tb/tb_serial_paralelo.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo.sv
// Receive-side deserializer: aligns a 1-bit MSB-first stream on COMMA and rebuilds bytes.
// Optional off-boundary comma realignment is enabled by defining SP_MISALIGN_DETECT_EN.
module serial_paralelo #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t      state, state_nx;
  logic [7:0]  sr;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [3:0]  bc_cnt, bc_cnt_nx;
  logic [7:0]  data_nx;
  logic        valid_nx, strobe_nx, active_nx;
  logic [7:0]  word;
  logic        word_is_comma;
  logic        boundary;

`ifdef SP_MISALIGN_DETECT_EN
  // last_was_comma lags one slot behind comma_q so that the garbage boundary word
  // produced by a bit slip does not hide the slipped comma that follows it.
  logic        comma_q, comma_q_nx;
  logic        last_was_comma, last_was_comma_nx;
`endif

  assign word          = {sr[6:0], data_in};
  assign word_is_comma = (word == COMMA);
  assign boundary      = (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state       <= SEARCH;
      sr          <= 8'd0;
      bit_cnt     <= 3'd0;
      bc_cnt      <= 4'd0;
      data_out    <= 8'd0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
`ifdef SP_MISALIGN_DETECT_EN
      comma_q        <= 1'b0;
      last_was_comma <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      sr          <= word;
      bit_cnt     <= bit_cnt_nx;
      bc_cnt      <= bc_cnt_nx;
      data_out    <= data_nx;
      valid_out   <= valid_nx;
      byte_strobe <= strobe_nx;
      active      <= active_nx;
`ifdef SP_MISALIGN_DETECT_EN
      comma_q        <= comma_q_nx;
      last_was_comma <= last_was_comma_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    bc_cnt_nx  = bc_cnt;
    data_nx    = data_out;
    valid_nx   = valid_out;
    strobe_nx  = 1'b0;
    active_nx  = active;
`ifdef SP_MISALIGN_DETECT_EN
    comma_q_nx        = comma_q;
    last_was_comma_nx = last_was_comma;
`endif
    case (state)
      SEARCH: begin
        valid_nx  = 1'b0;
        active_nx = 1'b0;
        // Any phase may start a lock attempt; this edge becomes the byte boundary.
        if (word_is_comma) begin
          bit_cnt_nx = 3'd0;
          bc_cnt_nx  = 4'd1;
          if (LOCK_N == 4'd1) begin
            state_nx  = ACTIVE;
            active_nx = 1'b1;
`ifdef SP_MISALIGN_DETECT_EN
            comma_q_nx        = 1'b1;
            last_was_comma_nx = 1'b1;
`endif
          end else begin
            state_nx = LOCKING;
          end
        end
      end
      LOCKING: begin
        bit_cnt_nx = bit_cnt + 3'd1;
        if (boundary) begin
          if (word_is_comma) begin
            bc_cnt_nx = bc_cnt + 4'd1;
            if (bc_cnt + 4'd1 == LOCK_N) begin
              state_nx  = ACTIVE;
              active_nx = 1'b1;
`ifdef SP_MISALIGN_DETECT_EN
              comma_q_nx        = 1'b1;
              last_was_comma_nx = 1'b1;
`endif
            end
          end else begin
            state_nx  = SEARCH;
            bc_cnt_nx = 4'd0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_nx = bit_cnt + 3'd1;
        if (boundary) begin
          strobe_nx = 1'b1;
          if (word_is_comma) begin
            valid_nx = 1'b0;
          end else begin
            data_nx  = word;
            valid_nx = 1'b1;
          end
`ifdef SP_MISALIGN_DETECT_EN
          last_was_comma_nx = comma_q;
          comma_q_nx        = word_is_comma;
`endif
        end
`ifdef SP_MISALIGN_DETECT_EN
        else if (word_is_comma && last_was_comma) begin
          // Comma landed off the boundary during idle: realign on this edge.
          state_nx   = LOCKING;
          active_nx  = 1'b0;
          valid_nx   = 1'b0;
          bit_cnt_nx = 3'd0;
          bc_cnt_nx  = 4'd1;
        end
`endif
      end
      default: begin
        state_nx = SEARCH;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_paralelo.sv
// Scoreboard bench for serial_paralelo: stimulus queues expected slot contents, a monitor
// pops one entry per byte_strobe. Honors SP_MISALIGN_DETECT_EN for the slip scenario.
module tb_serial_paralelo;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int         total = 0;
  int         bad   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_slot;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo #(.COMMA(8'hBC), .LOCK_COUNT(4)) dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest queued slot expectation.
  always @(negedge clk_32f) begin
    if (reset_L && byte_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL strobe_unexpected: got data=%0h valid=%0b expected no strobe",
                 data_out, valid_out);
      end else begin
        exp_slot = exp_q.pop_front();
        check("slot", 32'({valid_out, data_out}), 32'(exp_slot));
      end
    end
  end

  task automatic send_bit(input logic b);
    data_in = b;
    @(negedge clk_32f);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  initial begin
    logic [7:0] b;
    repeat (2) @(negedge clk_32f);
    check("rst_data",   32'(data_out),    32'h00);
    check("rst_valid",  32'(valid_out),   32'h0);
    check("rst_strobe", 32'(byte_strobe), 32'h0);
    check("rst_active", 32'(active),      32'h0);
    reset_L = 1'b1;

    // Garbage then four commas: lock completes on the 35th edge.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (3) send_byte(8'hBC);
    check("lock_pre_active", 32'(active), 32'h0);
    send_byte(8'hBC);
    check("lock_active", 32'(active),    32'h1);
    check("lock_valid",  32'(valid_out), 32'h0);

    exp_q.push_back({1'b1, 8'hA5});
    send_byte(8'hA5);
    check("a5_data",  32'(data_out),  32'hA5);
    check("a5_valid", 32'(valid_out), 32'h1);

    exp_q.push_back({1'b1, 8'h3C});
    b = 8'h3C;
    for (int i = 7; i >= 4; i--) send_bit(b[i]);
    check("hold_data",   32'(data_out),    32'hA5);
    check("hold_valid",  32'(valid_out),   32'h1);
    check("hold_strobe", 32'(byte_strobe), 32'h0);
    for (int i = 3; i >= 0; i--) send_bit(b[i]);
    check("3c_data", 32'(data_out), 32'h3C);

    exp_q.push_back({1'b0, 8'h3C});
    send_byte(8'hBC);
    check("idle_data",  32'(data_out),  32'h3C);
    check("idle_valid", 32'(valid_out), 32'h0);

    exp_q.push_back({1'b1, 8'h7E});
    send_byte(8'h7E);
    check("7e_data",  32'(data_out),  32'h7E);
    check("7e_valid", 32'(valid_out), 32'h1);

    // Asynchronous reset in the middle of a byte while active.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    #2 reset_L = 1'b0;
    #1;
    check("async_data",   32'(data_out),    32'h00);
    check("async_valid",  32'(valid_out),   32'h0);
    check("async_strobe", 32'(byte_strobe), 32'h0);
    check("async_active", 32'(active),      32'h0);
    repeat (3) @(negedge clk_32f);
    reset_L = 1'b1;

    // Lock abort: a non-comma at a boundary restarts the search.
    send_byte(8'hBC);
    send_byte(8'hBC);
    check("abort_2c", 32'(active), 32'h0);
    send_byte(8'h00);
    check("abort_00", 32'(active), 32'h0);
    repeat (3) send_byte(8'hBC);
    check("abort_3c", 32'(active), 32'h0);
    send_byte(8'hBC);
    check("relock_active", 32'(active), 32'h1);

    // Idle commas, then a one-bit slip.
    exp_q.push_back({1'b0, 8'h00});
    send_byte(8'hBC);
    exp_q.push_back({1'b0, 8'h00});
    send_byte(8'hBC);
    check("idle_active", 32'(active), 32'h1);
    send_bit(1'b0);
`ifdef SP_MISALIGN_DETECT_EN
    exp_q.push_back({1'b1, 8'h5E});
`else
    repeat (4) exp_q.push_back({1'b1, 8'h5E});
`endif
    send_byte(8'hBC);
    check("slip_data", 32'(data_out), 32'h5E);
`ifdef SP_MISALIGN_DETECT_EN
    check("slip_active", 32'(active),    32'h0);
    check("slip_valid",  32'(valid_out), 32'h0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    check("realign_pre", 32'(active), 32'h0);
`else
    check("slip_active", 32'(active),    32'h1);
    check("slip_valid",  32'(valid_out), 32'h1);
    send_byte(8'hBC);
    send_byte(8'hBC);
`endif
    send_byte(8'hBC);
    check("slip_end_active", 32'(active), 32'h1);

    repeat (2) @(negedge clk_32f);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
